// File: rtl/tuner_iq_sched.sv
// tuner_iq_sched: time-shares one sine-LUT x sample slice as both the I (cosine) and Q (sine) tuner legs.
// Owns the NCO accumulator, the frequency/phase-clear handshakes and the re-pairing of slice results into I/Q.
module tuner_iq_sched #(
    parameter int dsz = 10,
    parameter int psz = 12,
    parameter int fsz = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [dsz-1:0] in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [fsz-1:0]        freq,
    input  logic                  freq_load,
    output logic                  freq_ack,
    input  logic                  phs_clr,
    output logic [psz-1:0]        slc_phs,
    output logic                  slc_shf_90,
    output logic signed [dsz-1:0] slc_in,
    input  logic signed [dsz-1:0] slc_out,
    output logic signed [dsz-1:0] i_out,
    output logic signed [dsz-1:0] q_out,
    output logic                  out_valid
);
    localparam int slc_lat = 4;
    localparam int tag_len = 6;

    typedef enum logic [1:0] {IDLE, ISS_I, ISS_Q} state_t;

    state_t                state, state_nxt;
    logic                  accept, freq_go, clr_go;
    logic [fsz-1:0]        acc, acc_nxt, freq_reg, freq_pend;
    logic                  freq_flag, clr_pend;
    logic signed [dsz-1:0] samp, i_hold;
    logic signed [dsz-1:0] dly [slc_lat];
    // each tag is {valid, is_i}, travelling in step with the slice pipeline
    logic [1:0]            tag [tag_len];

    assign slc_in = dly[slc_lat-1];

    always_comb begin
        in_ready  = state != ISS_I;
        accept    = in_valid && in_ready;
        state_nxt = accept ? ISS_I : (state == ISS_I ? ISS_Q : IDLE);
        freq_go   = (freq_load || freq_flag) && state != ISS_Q;
        clr_go    = (phs_clr || clr_pend) && state != ISS_I;
        acc_nxt   = clr_go ? '0 : (state == ISS_Q ? acc + freq_reg : acc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            freq_reg   <= '0;
            freq_pend  <= '0;
            freq_flag  <= 1'b0;
            clr_pend   <= 1'b0;
            freq_ack   <= 1'b0;
            samp       <= '0;
            i_hold     <= '0;
            slc_phs    <= '0;
            slc_shf_90 <= 1'b0;
            i_out      <= '0;
            q_out      <= '0;
            out_valid  <= 1'b0;
            dly        <= '{default: '0};
            tag        <= '{default: '0};
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            freq_flag  <= !freq_go && (freq_load || freq_flag);
            clr_pend   <= !clr_go && (phs_clr || clr_pend);
            freq_ack   <= freq_go;
            slc_shf_90 <= state_nxt == ISS_I;
            out_valid  <= tag[tag_len-1] == 2'b10;
            dly[0]     <= samp;
            tag[0]     <= {state != IDLE, state == ISS_I};
            for (int k = 1; k < slc_lat; k++) dly[k] <= dly[k-1];
            for (int k = 1; k < tag_len; k++) tag[k] <= tag[k-1];
            if (accept) samp <= in;
            if (freq_load) freq_pend <= freq;
            // a strobe arriving outside ISS_Q is applied on the same edge, skipping the pending register
            if (freq_go) freq_reg <= freq_load ? freq : freq_pend;
            if (state_nxt != IDLE) slc_phs <= acc_nxt[fsz-1 -: psz];
            if (tag[tag_len-1] == 2'b11) i_hold <= slc_out;
            if (tag[tag_len-1] == 2'b10) begin
                i_out <= i_hold;
                q_out <= slc_out;
            end
        end
    end
endmodule
